// File: rtl/uart_pkg.sv
// Shared types and default sizing for the FIFO-fed UART transmitter.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps on terminal count, clears on request.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Free-running period counter, restarted on clear or terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr || tc) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops characters from an upstream registered-read FIFO
// and serialises them as start + LSB-first data + stop, no parity.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    tx_state_e             state_r, state_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s;
    logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_s;
    logic [CNT_W-1:0]      baud_cnt_s;
    logic                  baud_tc_s;
    logic                  baud_clr_s;
    logic                  tx_r, tx_s;
    logic                  busy_r, busy_s;
    logic                  read_en_r, read_en_s;
    logic                  frame_done_r, frame_done_s;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr_s),
        .cnt   (baud_cnt_s),
        .tc    (baud_tc_s)
    );

    // Next-state, datapath and next-output decode; outputs are registered so they align with state.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        case (state_r)
            IDLE: begin
                if (enable && !fifo_empty) state_s = FETCH;
                else                       state_s = IDLE;
            end
            FETCH: state_s = LOAD;
            LOAD: begin
                shift_s = fifo_data;
                state_s = START;
            end
            START: begin
                if (baud_tc_s) begin
                    state_s   = DATA;
                    bit_cnt_s = '0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (baud_tc_s) begin
                    shift_s   = {1'b0, shift_r[DATA_WIDTH-1:1]};
                    bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    if (bit_cnt_r == BIT_W'(DATA_WIDTH - 1)) state_s = STOP;
                    else                                     state_s = DATA;
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (baud_tc_s) begin
                    if (enable && !fifo_empty) state_s = FETCH;
                    else                       state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: state_s = IDLE;
        endcase

        baud_clr_s = (state_s != state_r);
        read_en_s  = (state_s == FETCH);
        busy_s     = (state_s != IDLE);
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            default: tx_s = 1'b1;
        endcase
        // Next cycle is the final stop-bit cycle when the counter is one short of terminal.
        frame_done_s = (state_r == STOP) && (state_s == STOP) &&
                       (baud_cnt_s == CNT_W'(CLKS_PER_BIT - 2));
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            read_en_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            tx_r         <= tx_s;
            busy_r       <= busy_s;
            read_en_r    <= read_en_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign fifo_read_en = read_en_r;
    assign tx           = tx_r;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per character; it equals the upstream FIFO data width.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2 to 65535.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high permits starting new frames.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_data  input  DATA_WIDTH  upstream FIFO read data, valid the cycle after fifo_read_en is high (registered read).
REQ-008 fifo_read_en  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-009 tx  output  1  serial line: idle high, LSB first, 1 start bit, DATA_WIDTH data bits, 1 stop bit, no parity.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_done  output  1  one-cycle pulse in the last clk cycle of each stop bit.

Function
REQ-012 States SHALL be IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-013 IDLE -> FETCH when enable=1 and fifo_empty=0; otherwise remain in IDLE.
REQ-014 FETCH lasts 1 cycle; fifo_read_en=1 only in FETCH (Moore output), then -> LOAD.
REQ-015 LOAD lasts 1 cycle; fifo_data is captured into the shift register, then -> START.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then -> DATA.
REQ-017 DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; -> STOP after DATA_WIDTH bits.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; on the last cycle -> FETCH if enable=1 and fifo_empty=0, else -> IDLE.
REQ-019 tx SHALL be 1 in IDLE, FETCH and LOAD.
REQ-020 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-021 Back-to-back frames SHALL be separated by exactly 2 extra tx-high cycles (FETCH, LOAD).
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and clear on every state change.
REQ-023 The bit counter SHALL be $clog2(DATA_WIDTH)+1 bits wide and clear on entry to DATA.
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next FETCH.
REQ-025 fifo_empty changes after FETCH SHALL NOT affect the frame in progress.
REQ-026 fifo_read_en SHALL never be asserted while fifo_empty=1 at the IDLE/STOP decision cycle; this guarantees no underflow pop.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, tx=1, busy=0, fifo_read_en=0, frame_done=0, and clear the counters and shift register.
REQ-028 Reset mid-frame SHALL abandon the character; a byte already popped is lost and SHALL NOT be re-requested.
REQ-029 After rst_n rises, the first FETCH SHALL occur no earlier than the first rising edge on which enable=1 and fifo_empty=0.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state enumeration type and the default DATA_WIDTH/CLKS_PER_BIT constants.
REQ-031 One sub-module, uart_baud_cnt (parameterised counter with clear input and terminal-count output), SHALL generate the bit-period tick.
REQ-032 The FSM, shift register and bit counter SHALL reside in fifo_uart_tx; the block SHALL instantiate no FIFO.

Verification (bench: CLKS_PER_BIT=4, DATA_WIDTH=8, paired with the team FIFO)
REQ-033 Reset with an idle FIFO -> tx=1, busy=0, fifo_read_en=0 for 20 cycles.
REQ-034 Write 8'h05, enable=1 -> one fifo_read_en pulse; tx=0 for 4 cycles, then bits 1,0,1,0,0,0,0,0 for 4 cycles each, then 1 for 4 cycles; frame_done pulses once; frame is 40 cycles.
REQ-035 Write 8'd5, 10, 15, 20, 25, 30, 35 -> seven frames in order, each 40 cycles, 2-cycle high gap between frames, exactly 7 pops, then IDLE with fifo_empty=1.
REQ-036 Preload 2 bytes with enable=0 -> no pop; raise enable -> both sent; drop enable during the first data bit -> first frame completes, second is not fetched.
REQ-037 Assert rst_n=0 during data bit 3 of 8'hA5 -> tx=1 and busy=0 within the same cycle; after release, the next queued byte is sent intact and 8'hA5 is not resent.
REQ-038 Checker on every cycle: fifo_read_en=1 implies fifo_empty=0; the serial line decoded by the bench monitor matches the FIFO write order.
